// File: rtl/simd_mult_rr_scheduler_pkg.sv
// Shared mode encodings and the response record that travels from the
// multiplier result pipe into the response FIFO.
package simd_mult_pkg;

    localparam logic [1:0] MODE_16X16     = 2'b00;
    localparam logic [1:0] MODE_SUM_16X16 = 2'b01;
    localparam logic [1:0] MODE_SUM_8X8   = 2'b10;
    localparam logic [1:0] MODE_SUM_4X4   = 2'b11;

    // Wide enough for the largest supported requester count (8).
    localparam int RSP_ID_W = 3;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [1:0]          mode;
        logic [31:0]         result_0;
        logic [31:0]         result_1;
        logic [3:0]          carry;
    } mult_rsp_t;

endpackage

// File: rtl/simd_mult_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer
// and moves the pointer just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     advance_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] idx_s;
    logic          found_s;
    logic          take_s;

    // Scan requesters starting at the pointer, wrapping past the top index.
    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found_s    = 1'b0;
        idx_s      = '0;
        take_s     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s          = PW'((int'(ptr_q) + k) % N_REQ);
            take_s         = ~found_s & req_i[idx_s];
            grant_o[idx_s] = take_s;
            grant_id_o     = take_s ? idx_s : grant_id_o;
            found_s        = found_s | req_i[idx_s];
        end
    end

    // Pointer update: one past the granted requester, modulo N_REQ.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= (grant_id_o == PW'(N_REQ - 1)) ? '0 : grant_id_o + PW'(1);
        end
    end

endmodule

// File: rtl/simd_mult_rr_scheduler.sv
// Shares one SIMD multiplier among N_REQ requesters: round-robin issue,
// fixed-latency result pipe and a credit-protected in-order response FIFO.
module simd_mult_rr_scheduler
    import simd_mult_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_LAT    = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [16*N_REQ-1:0]      req_a_i,
    input  logic [16*N_REQ-1:0]      req_b_i,
    input  logic [N_REQ-1:0]         req_a_sign_i,
    input  logic [N_REQ-1:0]         req_b_sign_i,
    input  logic [2*N_REQ-1:0]       req_mode_i,
    output logic [15:0]              mul_a_o,
    output logic [15:0]              mul_b_o,
    output logic                     mul_a_sign_o,
    output logic                     mul_b_sign_o,
    output logic [1:0]               mul_mode_o,
    input  logic [31:0]              mul_result_0_i,
    input  logic [31:0]              mul_result_1_i,
    input  logic [3:0]               mul_carry_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [1:0]               rsp_mode_o,
    output logic [31:0]              rsp_result_0_o,
    output logic [31:0]              rsp_result_1_o,
    output logic [3:0]               rsp_carry_o,
    output logic                     busy_o
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    logic [CW-1:0]    credits_q, credits_d;
    logic             can_issue_s, issue_s, wr_s, pop_s;
    logic [N_REQ-1:0] grant_s;
    logic [IDW-1:0]   gnt_id_s, iss_id_q;
    logic             iss_v_q;
    logic [15:0]      sel_a_s, sel_b_s;
    logic             sel_as_s, sel_bs_s;
    logic [1:0]       sel_mode_s;
    mult_rsp_t        stage_in_s;
    mult_rsp_t        pipe_q [MUL_LAT];
    logic [MUL_LAT-1:0] pipe_v_q;
    mult_rsp_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    // Registered credits only: a pop in this cycle frees a slot next cycle.
    assign can_issue_s = enable_i & (credits_q != '0) & ~reset_i;
    assign issue_s     = |grant_s;
    assign req_ready_o = grant_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_valid_i & {N_REQ{can_issue_s}}),
        .advance_i  (issue_s),
        .grant_o    (grant_s),
        .grant_id_o (gnt_id_s)
    );

    // One-hot AND-OR selection of the granted requester's operands.
    always_comb begin
        sel_a_s    = '0;
        sel_b_s    = '0;
        sel_as_s   = 1'b0;
        sel_bs_s   = 1'b0;
        sel_mode_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s    = sel_a_s | ({16{grant_s[i]}} & req_a_i[i*16 +: 16]);
            sel_b_s    = sel_b_s | ({16{grant_s[i]}} & req_b_i[i*16 +: 16]);
            sel_as_s   = sel_as_s | (grant_s[i] & req_a_sign_i[i]);
            sel_bs_s   = sel_bs_s | (grant_s[i] & req_b_sign_i[i]);
            sel_mode_s = sel_mode_s | ({2{grant_s[i]}} & req_mode_i[i*2 +: 2]);
        end
    end

    // Multiplier port registers hold the last issued op until the next issue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            mul_a_sign_o <= 1'b0;
            mul_b_sign_o <= 1'b0;
            mul_mode_o   <= '0;
            iss_id_q     <= '0;
            iss_v_q      <= 1'b0;
        end else begin
            iss_v_q <= issue_s;
            if (issue_s) begin
                mul_a_o      <= sel_a_s;
                mul_b_o      <= sel_b_s;
                mul_a_sign_o <= sel_as_s;
                mul_b_sign_o <= sel_bs_s;
                mul_mode_o   <= sel_mode_s;
                iss_id_q     <= gnt_id_s;
            end
        end
    end

    assign stage_in_s = '{id:       RSP_ID_W'(iss_id_q),
                          mode:     mul_mode_o,
                          result_0: mul_result_0_i,
                          result_1: mul_result_1_i,
                          carry:    mul_carry_i};

    // Result pipe: stage 0 captures the multiplier output one cycle after issue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_v_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0] <= iss_v_q;
            pipe_q[0]   <= stage_in_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_q[i]   <= pipe_q[i-1];
            end
        end
    end

    // Credits guarantee a free slot for every pipe entry, so writes never stall.
    assign wr_s  = pipe_v_q[MUL_LAT-1];
    assign pop_s = (cnt_q != '0) & rsp_ready_i;

    // Response FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_s) begin
                mem_q[wr_ptr_q] <= pipe_q[MUL_LAT-1];
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(wr_s) - CW'(pop_s);
        end
    end

    // Credit bookkeeping: issue consumes, pop returns.
    always_comb begin
        credits_d = credits_q;
        case ({issue_s, pop_s})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // Credit register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q <= CW'(FIFO_DEPTH);
        end else begin
            credits_q <= credits_d;
        end
    end

    assign rsp_valid_o    = (cnt_q != '0);
    assign rsp_id_o       = mem_q[rd_ptr_q].id[IDW-1:0];
    assign rsp_mode_o     = mem_q[rd_ptr_q].mode;
    assign rsp_result_0_o = mem_q[rd_ptr_q].result_0;
    assign rsp_result_1_o = mem_q[rd_ptr_q].result_1;
    assign rsp_carry_o    = mem_q[rd_ptr_q].carry;
    assign busy_o         = (credits_q != CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_simd_mult_rr_scheduler.sv
// Directed bench for simd_mult_rr_scheduler with a behavioural stub multiplier.
module tb_simd_mult_rr_scheduler;
    import simd_mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, rsp_ready;
    logic [3:0]  req_valid, req_ready, req_a_sign, req_b_sign;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_mode;
    logic [15:0] mul_a, mul_b;
    logic        mul_a_sign, mul_b_sign;
    logic [1:0]  mul_mode;
    logic [31:0] mul_result_0, mul_result_1;
    logic [3:0]  mul_carry;
    logic        rsp_valid, busy;
    logic [1:0]  rsp_id, rsp_mode;
    logic [31:0] rsp_result_0, rsp_result_1;
    logic [3:0]  rsp_carry;

    int n_chk = 0;
    int n_err = 0;
    int npop, nis;

    always #5 clk = ~clk;

    assign mul_result_0 = {16'h0000, mul_a} * {16'h0000, mul_b};
    assign mul_result_1 = {mul_b, mul_a};
    assign mul_carry    = {2'b00, mul_mode};

    simd_mult_rr_scheduler dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .req_a_sign_i(req_a_sign), .req_b_sign_i(req_b_sign), .req_mode_i(req_mode),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_a_sign_o(mul_a_sign),
        .mul_b_sign_o(mul_b_sign), .mul_mode_o(mul_mode),
        .mul_result_0_i(mul_result_0), .mul_result_1_i(mul_result_1), .mul_carry_i(mul_carry),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_mode_o(rsp_mode), .rsp_result_0_o(rsp_result_0),
        .rsp_result_1_o(rsp_result_1), .rsp_carry_o(rsp_carry), .busy_o(busy)
    );

    typedef struct {
        logic [1:0]  id;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  mode;
        logic        as;
        logic        bs;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [3:0]  c;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0; enable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(10 + i);
            req_b[i*16 +: 16] = 16'h0001;
            req_mode[i*2 +: 2] = MODE_16X16;
        end
        req_a_sign = '0;
        req_b_sign = '0;
    endtask

    task automatic wait_idle(input string nm);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            done = ~busy;
        end
        chk(nm, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'd0, 16'h0003, 16'h0005, MODE_16X16,     1'b0, 1'b0, 32'h0000000F, 32'h00050003, 4'h0};
        vecs[1] = '{2'd1, 16'hFFFF, 16'hFFFF, MODE_SUM_16X16, 1'b1, 1'b0, 32'hFFFE0001, 32'hFFFFFFFF, 4'h1};
        vecs[2] = '{2'd2, 16'h1234, 16'h0010, MODE_SUM_8X8,   1'b0, 1'b1, 32'h00012340, 32'h00101234, 4'h2};
        vecs[3] = '{2'd3, 16'h8000, 16'h0002, MODE_SUM_4X4,   1'b1, 1'b1, 32'h00010000, 32'h00028000, 4'h3};
        vecs[4] = '{2'd0, 16'h0000, 16'hABCD, MODE_16X16,     1'b0, 1'b1, 32'h00000000, 32'hABCD0000, 4'h0};

        reset = 1'b1; enable = 1'b1; rsp_ready = 1'b1; req_valid = '0;
        req_a = '0; req_b = '0; req_mode = '0; req_a_sign = '0; req_b_sign = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mul_a", {48'd0, mul_a}, 64'd0);
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_rsp_r0", {32'd0, rsp_result_0}, 64'd0);

        // Single-op vectors: grant, issue latency, response latency and payload.
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            req_a = '0; req_b = '0; req_mode = '0; req_a_sign = '0; req_b_sign = '0;
            req_a[vecs[v].id*16 +: 16]  = vecs[v].a;
            req_b[vecs[v].id*16 +: 16]  = vecs[v].b;
            req_mode[vecs[v].id*2 +: 2] = vecs[v].mode;
            req_a_sign[vecs[v].id]      = vecs[v].as;
            req_b_sign[vecs[v].id]      = vecs[v].bs;
            req_valid = 4'b0001 << vecs[v].id;
            @(negedge clk);
            chk("vec_grant", {60'd0, req_ready}, {60'd0, 4'b0001 << vecs[v].id});
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("vec_mul_a", {48'd0, mul_a}, {48'd0, vecs[v].a});
            chk("vec_mul_b", {48'd0, mul_b}, {48'd0, vecs[v].b});
            chk("vec_mul_mode", {62'd0, mul_mode}, {62'd0, vecs[v].mode});
            chk("vec_mul_signs", {62'd0, mul_a_sign, mul_b_sign}, {62'd0, vecs[v].as, vecs[v].bs});
            @(negedge clk);
            chk("vec_rsp_early", {63'd0, rsp_valid}, 64'd0);
            @(negedge clk);
            chk("vec_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("vec_rsp_id", {62'd0, rsp_id}, {62'd0, vecs[v].id});
            chk("vec_rsp_mode", {62'd0, rsp_mode}, {62'd0, vecs[v].mode});
            chk("vec_rsp_r0", {32'd0, rsp_result_0}, {32'd0, vecs[v].r0});
            chk("vec_rsp_r1", {32'd0, rsp_result_1}, {32'd0, vecs[v].r1});
            chk("vec_rsp_carry", {60'd0, rsp_carry}, {60'd0, vecs[v].c});
            chk("vec_mul_hold", {48'd0, mul_a}, {48'd0, vecs[v].a});
        end
        @(negedge clk);
        chk("vec_idle_busy", {63'd0, busy}, 64'd0);
        chk("vec_idle_valid", {63'd0, rsp_valid}, 64'd0);

        // Round-robin with all requesters valid and no backpressure.
        do_reset();
        load_all();
        req_valid = 4'hF;
        npop = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 6) chk("rr_grant", {60'd0, req_ready}, {60'd0, 4'b0001 << (c % 4)});
            if (rsp_valid) begin
                chk("rr_rsp_id", {62'd0, rsp_id}, 64'(npop % 4));
                chk("rr_rsp_r0", {32'd0, rsp_result_0}, 64'(10 + npop % 4));
                npop++;
            end
            @(posedge clk); #1;
            if (c == 5) req_valid = '0;
        end
        chk("rr_count", 64'(npop), 64'd6);

        // Backpressure: credits run out, then pop-without-bypass, then drain in order.
        do_reset();
        load_all();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        nis = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (|req_ready) nis++;
            @(posedge clk); #1;
        end
        chk("bp_issues", 64'(nis), 64'd4);
        @(negedge clk);
        chk("bp_ready_zero", {60'd0, req_ready}, 64'd0);
        chk("bp_busy", {63'd0, busy}, 64'd1);
        chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("pop_no_bypass", {60'd0, req_ready}, 64'd0);
        chk("pop_first_id", {62'd0, rsp_id}, 64'd0);
        npop = 1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("grant_after_pop", {60'd0, req_ready}, 64'd1);
        if (|req_ready) nis++;
        @(posedge clk); #1;
        @(negedge clk);
        chk("credits_zero_again", {60'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|req_ready) nis++;
            if (rsp_valid) begin
                chk("order_id", {62'd0, rsp_id}, 64'(npop % 4));
                chk("order_r0", {32'd0, rsp_result_0}, 64'(10 + npop % 4));
                npop++;
            end
            @(posedge clk); #1;
            if (c == 9) req_valid = '0;
        end
        chk("no_loss", 64'(npop), 64'(nis));
        chk("bp_drain_busy", {63'd0, busy}, 64'd0);

        // Reset with ops in flight flushes them and returns the pointer to 0.
        do_reset();
        load_all();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_mul_a", {48'd0, mul_a}, 64'd0);
        npop = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) npop++;
        end
        chk("flush_no_stale", 64'(npop), 64'd0);
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("flush_ptr0", {60'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("flush_drain");

        // enable=0 stops grants while in-flight ops still drain.
        do_reset();
        load_all();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("en_grant0", {60'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("en_grant2", {60'd0, req_ready}, 64'd4);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        enable = 1'b0;
        npop = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("en0_no_grant", {60'd0, req_ready}, 64'd0);
            if (rsp_valid) begin
                chk("en0_rsp_id", {62'd0, rsp_id}, (npop == 0) ? 64'd0 : 64'd2);
                npop++;
            end
            @(posedge clk); #1;
        end
        chk("en0_pops", 64'(npop), 64'd2);
        chk("en0_busy_fell", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("en1_grant1", {60'd0, req_ready}, 64'd2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("en_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
